// File: rtl/cpu_pkg.sv
// Shared constants, opcode/branch encodings and the MUL/DIV FSM state type
// for the 16-bit pipeline.
package cpu_pkg;
    localparam int DW = 16;
    localparam int RW = 3;

    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_MUL  = 4'd9;
    localparam logic [3:0] ALU_DIVU = 4'd10;
    localparam logic [3:0] ALU_REMU = 4'd11;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLT  = 3'd3;
    localparam logic [2:0] BR_BGE  = 3'd4;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

    // EX/MEM has priority over MEM/WB; r0 is hardwired to zero.
    function automatic logic [DW-1:0] fwd(
        input logic [RW-1:0] idx,
        input logic [DW-1:0] rf_val,
        input logic          exm_we,
        input logic [RW-1:0] exm_idx,
        input logic [DW-1:0] exm_val,
        input logic          mwb_we,
        input logic [RW-1:0] mwb_idx,
        input logic [DW-1:0] mwb_val
    );
        if (idx == '0)                        return '0;
        else if (exm_we && (exm_idx == idx))  return exm_val;
        else if (mwb_we && (mwb_idx == idx))  return mwb_val;
        else                                  return rf_val;
    endfunction
endpackage

// File: rtl/iter_muldiv.sv
// Iterative unsigned multiplier / restoring divider: one step per cycle,
// DW steps per operation, operands captured when the operation starts.
module iter_muldiv
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [3:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] result,
    output md_state_e     state
);
    localparam int CW = $clog2(DW);

    logic [CW-1:0] cnt;
    logic [3:0]    op_q;
    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic [DW-1:0] acc;
    logic [DW:0]   rem_shift;
    logic [DW:0]   rem_diff;
    logic          last;

    // Handshake: start is only sampled in IDLE; busy stays high from the start
    // cycle through the final step; done is a one-cycle pulse with result valid.
    assign busy   = ((state == MD_IDLE) && start) || (state == MD_BUSY);
    assign done   = (state == MD_DONE);
    assign result = (op_q == ALU_DIVU) ? a_q : acc;

    // For divide, a_q shifts out dividend bits and shifts in quotient bits;
    // acc holds the partial remainder. A borrow in bit DW means "restore".
    assign rem_shift = {acc, a_q[DW-1]};
    assign rem_diff  = rem_shift - {1'b0, b_q};
    assign last      = (cnt == CW'(DW - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MD_IDLE;
            cnt   <= '0;
            op_q  <= ALU_NOP;
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        a_q   <= a;
                        b_q   <= b;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    if (op_q == ALU_MUL) begin
                        if (b_q[0]) acc <= acc + a_q;
                        a_q <= a_q << 1;
                        b_q <= b_q >> 1;
                    end else if (!rem_diff[DW]) begin
                        acc <= rem_diff[DW-1:0];
                        a_q <= {a_q[DW-2:0], 1'b1};
                    end else begin
                        acc <= rem_shift[DW-1:0];
                        a_q <= {a_q[DW-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (last) state <= MD_DONE;
                end
                MD_DONE: state <= MD_IDLE;
                default: state <= MD_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, branch resolution and
// the iterative MUL/DIV unit that stalls upstream stages while it works.
module ex_stage
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] pc,
    input  logic [DW-1:0] rd1,
    input  logic [DW-1:0] rd2,
    input  logic [DW-1:0] imm,
    input  logic [RW-1:0] rs,
    input  logic [RW-1:0] rt,
    input  logic [RW-1:0] rd,
    input  logic [3:0]    alu_op,
    input  logic          alu_src,
    input  logic          reg_write_in,
    input  logic          mem_read_in,
    input  logic          mem_write_in,
    input  logic          mem_to_reg_in,
    input  logic [2:0]    branch,
    input  logic          exm_reg_write,
    input  logic [RW-1:0] exm_rd,
    input  logic [DW-1:0] exm_data,
    input  logic          mwb_reg_write,
    input  logic [RW-1:0] mwb_rd,
    input  logic [DW-1:0] mwb_data,
    output logic [DW-1:0] result,
    output logic [DW-1:0] store_data,
    output logic [RW-1:0] rd_out,
    output logic          reg_write_out,
    output logic          mem_read_out,
    output logic          mem_write_out,
    output logic          mem_to_reg_out,
    output logic          branch_taken,
    output logic [DW-1:0] branch_target,
    output logic          busy,
    output md_state_e     md_state
);
    logic [DW-1:0] fwd_a;
    logic [DW-1:0] fwd_b;
    logic [DW-1:0] op_b;
    logic [DW-1:0] alu_res;
    logic [DW-1:0] md_result;
    logic          md_op;
    logic          md_busy;
    logic          md_done;
    logic          ctrl_en;
    logic          cmp_true;

    assign fwd_a = fwd(rs, rd1, exm_reg_write, exm_rd, exm_data, mwb_reg_write, mwb_rd, mwb_data);
    assign fwd_b = fwd(rt, rd2, exm_reg_write, exm_rd, exm_data, mwb_reg_write, mwb_rd, mwb_data);
    assign op_b  = alu_src ? imm : fwd_b;
    assign md_op = is_muldiv(alu_op);

    iter_muldiv u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_op),
        .op     (alu_op),
        .a      (fwd_a),
        .b      (op_b),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result),
        .state  (md_state)
    );

    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD:  alu_res = fwd_a + op_b;
            ALU_SUB:  alu_res = fwd_a - op_b;
            ALU_AND:  alu_res = fwd_a & op_b;
            ALU_OR:   alu_res = fwd_a | op_b;
            ALU_XOR:  alu_res = fwd_a ^ op_b;
            ALU_SLT:  alu_res = {{(DW-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
            ALU_SLL:  alu_res = fwd_a << op_b[3:0];
            ALU_SRL:  alu_res = fwd_a >> op_b[3:0];
            ALU_MUL, ALU_DIVU, ALU_REMU: alu_res = md_done ? md_result : '0;
            default:  alu_res = '0;
        endcase
    end

    // Branch compares always use the forwarded rt, never the immediate.
    always_comb begin
        cmp_true = 1'b0;
        case (branch)
            BR_BEQ:  cmp_true = (fwd_a == fwd_b);
            BR_BNE:  cmp_true = (fwd_a != fwd_b);
            BR_BLT:  cmp_true = ($signed(fwd_a) <  $signed(fwd_b));
            BR_BGE:  cmp_true = ($signed(fwd_a) >= $signed(fwd_b));
            default: cmp_true = 1'b0;
        endcase
    end

    // A MUL/DIV instruction emits bubbles until its DONE cycle.
    assign ctrl_en = !rst && (alu_op != ALU_NOP) && (alu_op <= ALU_REMU) && (!md_op || md_done);

    assign result         = rst ? '0 : alu_res;
    assign store_data     = fwd_b;
    assign rd_out         = rd;
    assign reg_write_out  = ctrl_en && reg_write_in;
    assign mem_read_out   = ctrl_en && mem_read_in;
    assign mem_write_out  = ctrl_en && mem_write_in;
    assign mem_to_reg_out = ctrl_en && mem_to_reg_in;
    assign branch_taken   = !rst && (md_state != MD_BUSY) && cmp_true;
    assign branch_target  = pc + imm;
    assign busy           = !rst && md_busy;
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus random instructions,
// scored against a behavioural model through an expected-response queue.
module tb_ex_stage;
    import cpu_pkg::*;

    localparam int EW = 3 * DW + 5;

    logic          clk;
    logic          rst;
    logic [DW-1:0] pc, rd1, rd2, imm;
    logic [RW-1:0] rs, rt, rd;
    logic [3:0]    alu_op;
    logic          alu_src;
    logic          reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in;
    logic [2:0]    branch;
    logic          exm_reg_write, mwb_reg_write;
    logic [RW-1:0] exm_rd, mwb_rd;
    logic [DW-1:0] exm_data, mwb_data;
    logic [DW-1:0] result, store_data, branch_target;
    logic [RW-1:0] rd_out;
    logic          reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out;
    logic          branch_taken, busy;
    md_state_e     md_state;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    int            n_checks = 0;
    int            n_fail   = 0;
    logic          use_lit_res = 1'b0;
    logic [DW-1:0] lit_res;
    logic          use_lit_br = 1'b0;
    logic          lit_taken;

    ex_stage dut (
        .clk(clk), .rst(rst), .pc(pc), .rd1(rd1), .rd2(rd2), .imm(imm),
        .rs(rs), .rt(rt), .rd(rd), .alu_op(alu_op), .alu_src(alu_src),
        .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in),
        .branch(branch), .exm_reg_write(exm_reg_write), .exm_rd(exm_rd),
        .exm_data(exm_data), .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd),
        .mwb_data(mwb_data), .result(result), .store_data(store_data),
        .rd_out(rd_out), .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
        .mem_write_out(mem_write_out), .mem_to_reg_out(mem_to_reg_out),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .busy(busy), .md_state(md_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model
    function automatic logic [DW-1:0] ref_fwd(input logic [RW-1:0] idx, input logic [DW-1:0] rf);
        if (idx == 0) return 0;
        if (exm_reg_write && exm_rd == idx) return exm_data;
        if (mwb_reg_write && mwb_rd == idx) return mwb_data;
        return rf;
    endfunction

    function automatic logic [DW-1:0] ref_alu(input int op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        int unsigned ua, ub, p;
        ua = a;
        ub = b;
        case (op)
            1:  return DW'(ua + ub);
            2:  return DW'(ua - ub);
            3:  return a & b;
            4:  return a | b;
            5:  return a ^ b;
            6:  return ($signed(a) < $signed(b)) ? 1 : 0;
            7:  return DW'(ua << (ub % 16));
            8:  return DW'(ua >> (ub % 16));
            9:  begin p = ua * ub; return DW'(p); end
            10: return (ub == 0) ? 16'hFFFF : DW'(ua / ub);
            11: return (ub == 0) ? a : DW'(ua % ub);
            default: return 0;
        endcase
    endfunction

    function automatic logic ref_br(input int br, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (br)
            1: return a == b;
            2: return a != b;
            3: return $signed(a) < $signed(b);
            4: return $signed(a) >= $signed(b);
            default: return 0;
        endcase
    endfunction

    // driver tasks
    task automatic set_defaults();
        pc = 0; rd1 = 0; rd2 = 0; imm = 0; rs = 0; rt = 0; rd = 0;
        alu_op = 0; alu_src = 0; branch = 0;
        reg_write_in = 0; mem_read_in = 0; mem_write_in = 0; mem_to_reg_in = 0;
        exm_reg_write = 0; exm_rd = 0; exm_data = 0;
        mwb_reg_write = 0; mwb_rd = 0; mwb_data = 0;
        use_lit_res = 0; use_lit_br = 0;
    endtask

    task automatic issue();
        logic [DW-1:0] a, bb, b, res, tgt;
        logic          taken;
        logic [3:0]    ctrl;
        bit            is_md;
        int            exp_stall, k;
        a     = ref_fwd(rs, rd1);
        bb    = ref_fwd(rt, rd2);
        b     = alu_src ? imm : bb;
        res   = use_lit_res ? lit_res : ref_alu(int'(alu_op), a, b);
        taken = use_lit_br ? lit_taken : ref_br(int'(branch), a, bb);
        tgt   = pc + imm;
        ctrl  = (alu_op >= 1 && alu_op <= 11) ?
                {reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in} : 4'b0;
        is_md = (alu_op >= 9 && alu_op <= 11);
        if (alu_op != 0) exp_q.push_back({res, bb, tgt, taken, ctrl});
        exp_stall = is_md ? DW + 1 : 0;
        k = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            check("stall_ctrl", {reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out}, 0);
            if (k == 0) check("stall_state_idle", md_state, MD_IDLE);
            else begin
                check("stall_state_busy", md_state, MD_BUSY);
                check("stall_branch", branch_taken, 0);
            end
            k++;
            if (k > 64) begin
                check("stall_timeout", 1, 0);
                break;
            end
        end
        check("stall_cycles", k, exp_stall);
        @(posedge clk);
        #1;
        use_lit_res = 0;
        use_lit_br  = 0;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst && !busy && alu_op != 4'd0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("result", result, mon_e[EW-1 -: DW]);
                check("store_data", store_data, mon_e[2*DW+4 -: DW]);
                check("branch_target", branch_target, mon_e[DW+4 -: DW]);
                check("branch_taken", branch_taken, mon_e[4]);
                check("ctrl", {reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out}, mon_e[3:0]);
            end
        end
    end

    initial begin
        rst = 1'b1;
        set_defaults();
        alu_op = ALU_MUL; rs = 1; rd1 = 16'h0005; reg_write_in = 1; mem_read_in = 1;
        branch = BR_BNE; rt = 2; rd2 = 16'h0003;
        #3;
        check("rst_result", result, 0);
        check("rst_busy", busy, 0);
        check("rst_ctrl", {reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out}, 0);
        check("rst_branch", branch_taken, 0);
        check("rst_state", md_state, MD_IDLE);
        set_defaults();
        #9 rst = 1'b0;
        @(posedge clk); #1;

        // EX/MEM forward beats MEM/WB and the register file
        set_defaults();
        alu_op = ALU_ADD; rs = 1; rd1 = 16'h0005; rt = 2; rd2 = 16'h0003; reg_write_in = 1;
        exm_reg_write = 1; exm_rd = 1; exm_data = 16'h0010;
        mwb_reg_write = 1; mwb_rd = 1; mwb_data = 16'h0099;
        use_lit_res = 1; lit_res = 16'h0013;
        issue();

        // r0 is never forwarded
        set_defaults();
        alu_op = ALU_ADD; rs = 0; rd1 = 16'h5555; alu_src = 1; imm = 0; reg_write_in = 1;
        exm_reg_write = 1; exm_rd = 0; exm_data = 16'h1234;
        mwb_reg_write = 1; mwb_rd = 0; mwb_data = 16'h1234;
        use_lit_res = 1; lit_res = 16'h0000;
        issue();

        // only MEM/WB matches
        set_defaults();
        alu_op = ALU_ADD; rs = 3; rd1 = 16'h0009; alu_src = 1; imm = 0; reg_write_in = 1;
        exm_reg_write = 1; exm_rd = 4; exm_data = 16'h1111;
        mwb_reg_write = 1; mwb_rd = 3; mwb_data = 16'h0007;
        use_lit_res = 1; lit_res = 16'h0007;
        issue();

        // multi-cycle ops
        set_defaults();
        alu_op = ALU_MUL; rs = 1; rd1 = 16'h0123; alu_src = 1; imm = 16'h0010; reg_write_in = 1;
        use_lit_res = 1; lit_res = 16'h1230;
        issue();
        set_defaults();
        alu_op = ALU_DIVU; rs = 1; rd1 = 16'h0064; alu_src = 1; imm = 16'h0007; reg_write_in = 1;
        use_lit_res = 1; lit_res = 16'h000E;
        issue();
        set_defaults();
        alu_op = ALU_REMU; rs = 1; rd1 = 16'h0064; alu_src = 1; imm = 16'h0007; reg_write_in = 1;
        use_lit_res = 1; lit_res = 16'h0002;
        issue();
        set_defaults();
        alu_op = ALU_DIVU; rs = 1; rd1 = 16'h1234; rt = 2; rd2 = 0; reg_write_in = 1;
        use_lit_res = 1; lit_res = 16'hFFFF;
        issue();
        set_defaults();
        alu_op = ALU_REMU; rs = 1; rd1 = 16'h1234; rt = 2; rd2 = 0; reg_write_in = 1;
        use_lit_res = 1; lit_res = 16'h1234;
        issue();

        // signed branches
        set_defaults();
        alu_op = ALU_SUB; rs = 1; rd1 = 16'hFFFF; rt = 2; rd2 = 16'h0001;
        pc = 16'h0040; imm = 16'hFFF0; branch = BR_BLT;
        use_lit_br = 1; lit_taken = 1;
        issue();
        set_defaults();
        alu_op = ALU_SUB; rs = 1; rd1 = 16'hFFFF; rt = 2; rd2 = 16'h0001;
        pc = 16'h0040; imm = 16'hFFF0; branch = BR_BGE;
        use_lit_br = 1; lit_taken = 0;
        issue();

        // opcodes above REMU act as NOP
        set_defaults();
        alu_op = 4'd13; rs = 1; rd1 = 16'h00FF; rt = 2; rd2 = 16'h0F0F;
        reg_write_in = 1; mem_write_in = 1; mem_to_reg_in = 1;
        use_lit_res = 1; lit_res = 16'h0000;
        issue();

        // reset in the middle of a multiply
        set_defaults();
        alu_op = ALU_MUL; rs = 1; rd1 = 16'h0123; alu_src = 1; imm = 16'h0010; reg_write_in = 1;
        for (int i = 0; i < 6; i++) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_state", md_state, MD_IDLE);
        check("midrst_result", result, 0);
        check("midrst_ctrl", reg_write_out, 0);
        set_defaults();
        @(posedge clk);
        #2 rst = 1'b0;
        alu_op = ALU_ADD; rs = 1; rd1 = 16'h0001; rt = 2; rd2 = 16'h0001; reg_write_in = 1;
        use_lit_res = 1; lit_res = 16'h0002;
        issue();

        // random instruction stream
        for (int n = 0; n < 150; n++) begin
            set_defaults();
            alu_op = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 2) == 0) alu_op = 4'($urandom_range(9, 11));
            rs = RW'($urandom_range(0, 7));
            rt = RW'($urandom_range(0, 7));
            rd = RW'($urandom_range(0, 7));
            rd1 = DW'($urandom);
            rd2 = ($urandom_range(0, 7) == 0) ? 16'h0 : DW'($urandom_range(0, 1) ? $urandom : $urandom_range(1, 40));
            imm = ($urandom_range(0, 7) == 0) ? 16'h0 : DW'($urandom);
            alu_src = 1'($urandom_range(0, 1));
            pc = DW'($urandom);
            branch = 3'($urandom_range(0, 7));
            {reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in} = 4'($urandom);
            exm_reg_write = 1'($urandom_range(0, 1));
            exm_rd = RW'($urandom_range(0, 7));
            exm_data = DW'($urandom);
            mwb_reg_write = 1'($urandom_range(0, 1));
            mwb_rd = RW'($urandom_range(0, 7));
            mwb_data = DW'($urandom);
            issue();
        end

        set_defaults();
        @(negedge clk);
        check("queue_empty", exp_q.size(), 0);

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
